// File: rtl/exec_alu_if.sv
// exec_alu_if: issue and result-broadcast bundle between the reservation station side and exec_alu
interface exec_alu_if;
  logic        in_enable;
  logic [5:0]  in_openum;
  logic [4:0]  in_rob_pos;
  logic [31:0] in_rs1_val;
  logic [31:0] in_rs2_val;
  logic [31:0] in_imm;
  logic [31:0] in_pc;
  logic        result_ready;
  logic [4:0]  result_rob_pos;
  logic [31:0] result_val;
  logic        result_jump;
  logic [31:0] result_pc;
  logic        busy;
  modport master (
    output in_enable, in_openum, in_rob_pos, in_rs1_val, in_rs2_val, in_imm, in_pc,
    input  result_ready, result_rob_pos, result_val, result_jump, result_pc, busy
  );
  modport slave (
    input  in_enable, in_openum, in_rob_pos, in_rs1_val, in_rs2_val, in_imm, in_pc,
    output result_ready, result_rob_pos, result_val, result_jump, result_pc, busy
  );
endinterface

// File: rtl/exec_alu.sv
// exec_alu: RV32I execute unit with 1-cycle ALU/branch ops; defining ALU_MUL_EN adds a
// 32-step shift-add multiplier (MUL/MULH/MULHSU/MULHU) that holds busy while it runs.
module exec_alu (
  input  logic clk,
  input  logic rst,
  input  logic rdy,
  input  logic clr,
  exec_alu_if.slave bus
);
  localparam logic [5:0] OP_ADD = 6'd0, OP_SUB = 6'd1, OP_SLL = 6'd2, OP_SLT = 6'd3, OP_SLTU = 6'd4,
    OP_XOR = 6'd5, OP_SRL = 6'd6, OP_SRA = 6'd7, OP_OR = 6'd8, OP_AND = 6'd9, OP_ADDI = 6'd10,
    OP_SLTI = 6'd11, OP_SLTIU = 6'd12, OP_XORI = 6'd13, OP_ORI = 6'd14, OP_ANDI = 6'd15,
    OP_SLLI = 6'd16, OP_SRLI = 6'd17, OP_SRAI = 6'd18, OP_LUI = 6'd19, OP_AUIPC = 6'd20,
    OP_JAL = 6'd21, OP_JALR = 6'd22, OP_BEQ = 6'd23, OP_BNE = 6'd24, OP_BLT = 6'd25,
    OP_BGE = 6'd26, OP_BLTU = 6'd27, OP_BGEU = 6'd28, OP_MUL = 6'd29, OP_MULH = 6'd30,
    OP_MULHSU = 6'd31, OP_MULHU = 6'd32;
  logic        ready_q, jump_q, jump_d, take;
  logic [4:0]  tag_q, sh;
  logic [31:0] val_q, pc_q, val_d, pc_d, rs1, rs2, imm, pc, op2, pc4;
  always_comb begin
    rs1 = bus.in_rs1_val;
    rs2 = bus.in_rs2_val;
    imm = bus.in_imm;
    pc = bus.in_pc;
    op2 = (bus.in_openum inside {[OP_ADDI:OP_SRAI]}) ? imm : rs2;
    sh = op2[4:0];
    pc4 = pc + 32'd4;
    take = 1'b0;
    val_d = '0;
    jump_d = 1'b0;
    pc_d = pc4;
    case (bus.in_openum)
      OP_ADD, OP_ADDI:   val_d = rs1 + op2;
      OP_SUB:            val_d = rs1 - op2;
      OP_SLL, OP_SLLI:   val_d = rs1 << sh;
      OP_SLT, OP_SLTI:   val_d = {31'd0, $signed(rs1) < $signed(op2)};
      OP_SLTU, OP_SLTIU: val_d = {31'd0, rs1 < op2};
      OP_XOR, OP_XORI:   val_d = rs1 ^ op2;
      OP_SRL, OP_SRLI:   val_d = rs1 >> sh;
      OP_SRA, OP_SRAI:   val_d = $signed(rs1) >>> sh;
      OP_OR, OP_ORI:     val_d = rs1 | op2;
      OP_AND, OP_ANDI:   val_d = rs1 & op2;
      OP_LUI:            val_d = imm;
      OP_AUIPC:          val_d = pc + imm;
      OP_JAL:            begin val_d = pc4; jump_d = 1'b1; pc_d = pc + imm; end
      OP_JALR:           begin val_d = pc4; jump_d = 1'b1; pc_d = (rs1 + imm) & ~32'd1; end
      OP_BEQ:            take = rs1 == rs2;
      OP_BNE:            take = rs1 != rs2;
      OP_BLT:            take = $signed(rs1) < $signed(rs2);
      OP_BGE:            take = $signed(rs1) >= $signed(rs2);
      OP_BLTU:           take = rs1 < rs2;
      OP_BGEU:           take = rs1 >= rs2;
      default:           ;
    endcase
    if (take) begin
      jump_d = 1'b1;
      pc_d = pc + imm;
    end
  end
`ifdef ALU_MUL_EN
  typedef enum logic {IDLE, MUL_RUN} state_t;
  state_t      state_q;
  logic [5:0]  cnt_q;
  logic [31:0] mcand_q, mpc_q;
  logic [63:0] prod_q, prod_n, res64;
  logic [4:0]  mtag_q;
  logic        neg_q, hi_q, is_mul, an, bn;
  logic [32:0] sum;
  // prod_q holds {partial sum, remaining multiplier bits}; one shift-add step per edge
  always_comb begin
    is_mul = bus.in_openum inside {[OP_MUL:OP_MULHU]};
    an = (bus.in_openum == OP_MULH || bus.in_openum == OP_MULHSU) && rs1[31];
    bn = bus.in_openum == OP_MULH && rs2[31];
    sum = {1'b0, prod_q[63:32]} + (prod_q[0] ? {1'b0, mcand_q} : 33'd0);
    prod_n = {sum, prod_q[31:1]};
    res64 = neg_q ? -prod_n : prod_n;
  end
  assign bus.busy = state_q == MUL_RUN;
`else
  assign bus.busy = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q <= 1'b0;
      tag_q <= '0;
      val_q <= '0;
      jump_q <= 1'b0;
      pc_q <= '0;
`ifdef ALU_MUL_EN
      state_q <= IDLE;
      cnt_q <= '0;
`endif
    end else if (clr) begin
      ready_q <= 1'b0;
`ifdef ALU_MUL_EN
      state_q <= IDLE;
      cnt_q <= '0;
`endif
    end else if (rdy) begin
      ready_q <= 1'b0;
`ifdef ALU_MUL_EN
      if (state_q == MUL_RUN) begin
        prod_q <= prod_n;
        cnt_q <= cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          state_q <= IDLE;
          cnt_q <= '0;
          ready_q <= 1'b1;
          tag_q <= mtag_q;
          val_q <= hi_q ? res64[63:32] : res64[31:0];
          jump_q <= 1'b0;
          pc_q <= mpc_q;
        end
      end else if (bus.in_enable && is_mul) begin
        state_q <= MUL_RUN;
        cnt_q <= '0;
        mcand_q <= an ? -rs1 : rs1;
        prod_q <= {32'd0, bn ? -rs2 : rs2};
        neg_q <= an ^ bn;
        hi_q <= bus.in_openum != OP_MUL;
        mtag_q <= bus.in_rob_pos;
        mpc_q <= pc4;
      end else
`endif
      if (bus.in_enable) begin
        ready_q <= 1'b1;
        tag_q <= bus.in_rob_pos;
        val_q <= val_d;
        jump_q <= jump_d;
        pc_q <= pc_d;
      end
    end
  end
  assign bus.result_ready = ready_q;
  assign bus.result_rob_pos = tag_q;
  assign bus.result_val = val_q;
  assign bus.result_jump = jump_q;
  assign bus.result_pc = pc_q;
endmodule

// File: tb/tb_exec_alu.sv
// tb_exec_alu: directed literal cases plus randomized issue/rdy/clr/rst traffic, checked every
// cycle against a transaction-level reference model of exec_alu.
module tb_exec_alu;
  localparam logic [5:0] ADD = 0, SUB = 1, SLL = 2, SLT = 3, SLTU = 4, XOR_ = 5, SRL = 6, SRA = 7,
    OR_ = 8, AND_ = 9, ADDI = 10, SLTI = 11, SLTIU = 12, XORI = 13, ORI = 14, ANDI = 15, SLLI = 16,
    SRLI = 17, SRAI = 18, LUI = 19, AUIPC = 20, JAL = 21, JALR = 22, BEQ = 23, BNE = 24, BLT = 25,
    BGE = 26, BLTU = 27, BGEU = 28, MUL = 29, MULH = 30, MULHSU = 31, MULHU = 32;
`ifdef ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif
  typedef struct packed { logic [31:0] val; logic jump; logic [31:0] pc; } res_t;
  logic clk = 1'b0, rst = 1'b1, rdy = 1'b1, clr = 1'b0;
  exec_alu_if bus ();
  exec_alu dut (.clk(clk), .rst(rst), .rdy(rdy), .clr(clr), .bus(bus));
  always #5 clk = ~clk;
  int n_checks = 0, n_fail = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic res_t ref_exec(input logic [5:0] op, input logic [31:0] a, b, imm, pc);
    res_t r;
    logic [63:0] p;
    logic t;
    r.val = 0; r.jump = 0; r.pc = pc + 4; t = 0; p = 0;
    case (op)
      ADD: r.val = a + b;                 ADDI: r.val = a + imm;
      SUB: r.val = a - b;
      SLL: r.val = a << b[4:0];           SLLI: r.val = a << imm[4:0];
      SLT: r.val = ($signed(a) < $signed(b)) ? 1 : 0;
      SLTI: r.val = ($signed(a) < $signed(imm)) ? 1 : 0;
      SLTU: r.val = (a < b) ? 1 : 0;      SLTIU: r.val = (a < imm) ? 1 : 0;
      XOR_: r.val = a ^ b;                XORI: r.val = a ^ imm;
      SRL: r.val = a >> b[4:0];           SRLI: r.val = a >> imm[4:0];
      SRA: r.val = $signed(a) >>> b[4:0]; SRAI: r.val = $signed(a) >>> imm[4:0];
      OR_: r.val = a | b;                 ORI: r.val = a | imm;
      AND_: r.val = a & b;                ANDI: r.val = a & imm;
      LUI: r.val = imm;
      AUIPC: r.val = pc + imm;
      JAL: begin r.val = pc + 4; r.jump = 1; r.pc = pc + imm; end
      JALR: begin r.val = pc + 4; r.jump = 1; r.pc = (a + imm) & 32'hFFFF_FFFE; end
      BEQ: t = a == b;  BNE: t = a != b;
      BLT: t = $signed(a) < $signed(b);  BGE: t = $signed(a) >= $signed(b);
      BLTU: t = a < b;  BGEU: t = a >= b;
      MUL: if (MUL_EN) begin p = {32'd0, a} * {32'd0, b}; r.val = p[31:0]; end
      MULH: if (MUL_EN) begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; r.val = p[63:32]; end
      MULHSU: if (MUL_EN) begin p = {{32{a[31]}}, a} * {32'd0, b}; r.val = p[63:32]; end
      MULHU: if (MUL_EN) begin p = {32'd0, a} * {32'd0, b}; r.val = p[63:32]; end
      default: ;
    endcase
    if (t) begin r.jump = 1; r.pc = pc + imm; end
    return r;
  endfunction
  // Reference model: an M op waits `remain` edges before its result is published
  bit started = 0;
  logic e_ready = 0, e_jump = 0;
  logic [4:0] e_tag = 0, pend_tag = 0;
  logic [31:0] e_val = 0, e_pc = 0;
  int remain = 0;
  res_t r, pend;
  always @(posedge clk) begin
    started = 1;
    if (rst) begin
      e_ready = 0; e_tag = 0; e_val = 0; e_jump = 0; e_pc = 0; remain = 0;
    end else if (clr) begin
      e_ready = 0; remain = 0;
    end else if (rdy) begin
      e_ready = 0;
      if (remain > 0) begin
        remain--;
        if (remain == 0) begin
          e_ready = 1; e_tag = pend_tag; e_val = pend.val; e_jump = pend.jump; e_pc = pend.pc;
        end
      end else if (bus.in_enable) begin
        r = ref_exec(bus.in_openum, bus.in_rs1_val, bus.in_rs2_val, bus.in_imm, bus.in_pc);
        if (MUL_EN && bus.in_openum >= MUL && bus.in_openum <= MULHU) begin
          pend = r; pend_tag = bus.in_rob_pos; remain = 32;
        end else begin
          e_ready = 1; e_tag = bus.in_rob_pos; e_val = r.val; e_jump = r.jump; e_pc = r.pc;
        end
      end
    end
  end
  always @(negedge clk) if (started) begin
    check("m_ready", 32'(bus.result_ready), 32'(e_ready));
    check("m_busy", 32'(bus.busy), 32'(remain > 0));
    check("m_tag", 32'(bus.result_rob_pos), 32'(e_tag));
    check("m_val", bus.result_val, e_val);
    check("m_jump", 32'(bus.result_jump), 32'(e_jump));
    check("m_pc", bus.result_pc, e_pc);
  end
  task automatic set_in(input logic [5:0] op, input logic [4:0] tag, input logic [31:0] a, b, imm, pc);
    bus.in_enable = 1; bus.in_openum = op; bus.in_rob_pos = tag;
    bus.in_rs1_val = a; bus.in_rs2_val = b; bus.in_imm = imm; bus.in_pc = pc;
  endtask
  task automatic issue(input logic [5:0] op, input logic [4:0] tag, input logic [31:0] a, b, imm, pc);
    set_in(op, tag, a, b, imm, pc);
    @(negedge clk);
    bus.in_enable = 0;
  endtask
  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 5))
      0: return $urandom_range(0, 40);
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF - $urandom_range(0, 3);
      default: return $urandom();
    endcase
  endfunction
  int n, bad;
  res_t pin;
  initial begin
    set_in(ADD, 1, 0, 0, 0, 0);
    bus.in_enable = 0;
    pin = ref_exec(MULHSU, 32'hFFFF_FFFF, 2, 0, 0);
    check("model_mulhsu", pin.val, MUL_EN ? 32'hFFFF_FFFF : 32'h0);
    pin = ref_exec(SRAI, 32'h8000_0010, 0, 32'h24, 0);
    check("model_srai", pin.val, 32'hF800_0001);
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(bus.result_ready), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_tag", 32'(bus.result_rob_pos), 0);
    check("rst_val", bus.result_val, 0);
    check("rst_jump", 32'(bus.result_jump), 0);
    check("rst_pc", bus.result_pc, 0);
    rst = 0;
    @(negedge clk);
    issue(ADD, 3, 32'hFFFF_FFFF, 1, 0, 0);
    check("add_ready", 32'(bus.result_ready), 1);
    check("add_tag", 32'(bus.result_rob_pos), 3);
    check("add_val", bus.result_val, 0);
    check("add_jump", 32'(bus.result_jump), 0);
    issue(BLT, 4, 32'hFFFF_FFFE, 1, 32'h20, 32'h100);
    check("blt_jump", 32'(bus.result_jump), 1);
    check("blt_pc", bus.result_pc, 32'h120);
    issue(BLTU, 5, 32'hFFFF_FFFE, 1, 32'h20, 32'h100);
    check("bltu_jump", 32'(bus.result_jump), 0);
    check("bltu_pc", bus.result_pc, 32'h104);
    issue(JALR, 6, 32'h1003, 0, 4, 32'h40);
    check("jalr_val", bus.result_val, 32'h44);
    check("jalr_pc", bus.result_pc, 32'h1006);
    check("jalr_jump", 32'(bus.result_jump), 1);
    @(negedge clk);
    check("idle_ready", 32'(bus.result_ready), 0);
    check("idle_hold", bus.result_pc, 32'h1006);
`ifdef ALU_MUL_EN
    issue(MULH, 7, 32'hFFFF_FFFF, 2, 0, 32'h200);
    n = 0;
    while (bus.busy && n < 40) begin n++; @(negedge clk); end
    check("mulh_busy_cycles", n, 32);
    check("mulh_ready", 32'(bus.result_ready), 1);
    check("mulh_tag", 32'(bus.result_rob_pos), 7);
    check("mulh_val", bus.result_val, 32'hFFFF_FFFF);
    check("mulh_pc", bus.result_pc, 32'h204);
    issue(MULHU, 8, 32'hFFFF_FFFF, 2, 0, 32'h300);
    n = 0;
    while (bus.busy && n < 40) begin n++; @(negedge clk); end
    check("mulhu_busy_cycles", n, 32);
    check("mulhu_val", bus.result_val, 32'h1);
    issue(MUL, 9, 32'h1234, 32'h5678, 0, 0);
    repeat (9) @(negedge clk);
    clr = 1;
    @(negedge clk);
    clr = 0;
    check("clr_busy", 32'(bus.busy), 0);
    check("clr_ready", 32'(bus.result_ready), 0);
    bad = 0;
    repeat (40) begin @(negedge clk); if (bus.result_ready && bus.result_rob_pos == 9) bad++; end
    check("clr_no_strobe", bad, 0);
`else
    issue(MULH, 7, 32'hFFFF_FFFF, 2, 0, 32'h200);
    check("mulh_ready", 32'(bus.result_ready), 1);
    check("mulh_val", bus.result_val, 0);
    check("mulh_jump", 32'(bus.result_jump), 0);
    check("mulh_pc", bus.result_pc, 32'h204);
`endif
    issue(ADD, 4, 5, 6, 0, 0);
    check("post_add_ready", 32'(bus.result_ready), 1);
    check("post_add_val", bus.result_val, 11);
    issue(ADD, 1, 1, 1, 0, 0);
    check("b2b1_tag", 32'(bus.result_rob_pos), 1);
    set_in(ADD, 2, 2, 2, 0, 0);
    rdy = 0;
    @(negedge clk);
    check("frz1_ready", 32'(bus.result_ready), 1);
    check("frz1_tag", 32'(bus.result_rob_pos), 1);
    @(negedge clk);
    check("frz2_ready", 32'(bus.result_ready), 1);
    check("frz2_val", bus.result_val, 2);
    rdy = 1;
    @(negedge clk);
    check("b2b2_tag", 32'(bus.result_rob_pos), 2);
    check("b2b2_val", bus.result_val, 4);
    issue(ADD, 3, 3, 3, 0, 0);
    check("b2b3_tag", 32'(bus.result_rob_pos), 3);
    check("b2b3_ready", 32'(bus.result_ready), 1);
    @(negedge clk);
    check("b2b_end_ready", 32'(bus.result_ready), 0);
    for (int i = 0; i < 4000; i++) begin
      rst = $urandom_range(0, 299) == 0;
      clr = $urandom_range(0, 59) == 0;
      rdy = $urandom_range(0, 9) != 0;
      set_in(6'($urandom_range(0, 32)), 5'($urandom_range(1, 31)), rand_word(), rand_word(),
             rand_word(), $urandom() & 32'hFFFF_FFFC);
      bus.in_enable = $urandom_range(0, 1);
      @(negedge clk);
    end
    rst = 0; clr = 0; rdy = 1; bus.in_enable = 0;
    repeat (40) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/exec_alu.md
EXEC_ALU -- requirements
Module: exec_alu

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 rdy  input  1  global ready; when low, all state and outputs hold.
REQ-004 clr  input  1  pipeline flush (mispredict), synchronous.
REQ-005 in_enable  input  1  operation valid from reservation station; captured on the edge where it is high.
REQ-006 in_openum  input  6  decoded opcode enum (ADD..AND, LUI, AUIPC, JAL, JALR, BEQ..BGEU, MUL/MULH/MULHSU/MULHU).
REQ-007 in_rob_pos  input  5  destination ROB tag; 0 is never issued.
REQ-008 in_rs1_val, in_rs2_val, in_imm  input  32 each  operands and immediate.
REQ-009 in_pc  input  32  instruction address.
REQ-010 result_ready  output  1  one-cycle broadcast strobe to RS, LSB and ROB.
REQ-011 result_rob_pos  output  5  tag of the broadcast result.
REQ-012 result_val  output  32  rd value (pc+4 for JAL/JALR; 0 for branches).
REQ-013 result_jump  output  1  control transfer taken (JAL, JALR, taken branch).
REQ-014 result_pc  output  32  target: pc+imm for JAL/branches; (rs1+imm)&~1 for JALR; pc+4 otherwise.
REQ-015 busy  output  1  unit cannot accept in_enable this cycle.

Function
REQ-016 The state machine SHALL have states IDLE and MUL_RUN; busy = (state==MUL_RUN).
REQ-017 Non-M ops captured at edge E0 SHALL produce result_ready=1 in the cycle after E0, for exactly one cycle (latency 1, back-to-back throughput 1/cycle).
REQ-018 result_ready SHALL be 0 in every cycle without a completing operation; result_* data SHALL hold their last value.
REQ-019 Arithmetic SHALL be 32-bit wrap-around; shift amounts SHALL use bits [4:0] of rs2 or imm; SLT/BLT/BGE signed, SLTU/BLTU/BGEU unsigned.
REQ-020 In MUL_RUN the block SHALL run a 32-iteration shift-add on operand magnitudes with a 6-bit counter, one iteration per edge.
REQ-021 MUL/MULHU SHALL use unsigned operands; MULH SHALL treat both as signed; MULHSU only rs1 as signed; the 64-bit product SHALL be negated when signs differ.
REQ-022 MUL SHALL return product[31:0]; MULH/MULHSU/MULHU SHALL return product[63:32].
REQ-023 M op captured at E0: busy high in the 32 cycles after E0..E31; result written and state->IDLE at E32; result_ready high in the cycle after E32, with busy already 0.
REQ-024 in_enable while busy=1 is a protocol violation; the block SHALL ignore it and keep the running operation intact.
REQ-025 In the result_ready cycle of an M op a new in_enable SHALL be accepted normally.
REQ-026 clr SHALL force state IDLE, counter 0, result_ready 0 on the next edge, discarding any in-flight or simultaneously presented operation.
REQ-027 rdy low SHALL freeze state, counter and all outputs including result_ready; the operation resumes unchanged when rdy returns.
REQ-028 Precedence SHALL be rst > clr > !rdy > normal operation.

Reset
REQ-029 On rst: state IDLE, counter 0, result_ready 0, result_jump 0, result_rob_pos 0, result_val 0, result_pc 0, busy 0.
REQ-030 rst mid-multiply SHALL abort the operation with no result broadcast.

Configuration
REQ-031 Macro ALU_MUL_EN defined: REQ-016, REQ-020..REQ-025 apply.
REQ-032 ALU_MUL_EN undefined: no MUL_RUN state or multiplier datapath; busy tied 0; M opcodes complete in 1 cycle with result_val 0, result_jump 0.

Verification
REQ-033 ADD rs1=0xFFFFFFFF rs2=1 tag 3 -> next cycle result_ready=1, tag 3, result_val 0x00000000, result_jump 0.
REQ-034 BLT rs1=0xFFFFFFFE rs2=1 pc=0x100 imm=0x20 -> result_jump 1, result_pc 0x120; BLTU same operands -> result_jump 0, result_pc 0x104.
REQ-035 JALR rs1=0x1003 imm=4 pc=0x40 -> result_val 0x44, result_pc 0x1006, result_jump 1.
REQ-036 ALU_MUL_EN: MULH rs1=0xFFFFFFFF rs2=2 tag 7 -> busy 32 cycles, result_ready after 32nd run edge, result_val 0xFFFFFFFF; MULHU same -> 0x00000001.
REQ-037 ALU_MUL_EN: MUL accepted, clr pulsed at run cycle 10 -> busy 0 next cycle, no result_ready for tag; subsequent ADD completes in 1 cycle.
REQ-038 Back-to-back ADD tags 1,2,3 with rdy low for 2 cycles mid-stream -> three strobes in order, each exactly once, outputs frozen during rdy low.
